// File: rtl/beep_scheduler_pkg.sv
// Shared constants, state encoding, pattern table and arbiter helper for beep_scheduler.
package beep_scheduler_pkg;

   localparam int unsigned N_SRC     = 4;
   localparam int unsigned SEL_W     = 2;
   localparam int unsigned CNT_W     = 10;
   localparam int unsigned REP_W     = 3;
   localparam int unsigned ALARM_IDX = N_SRC - 1;
   localparam int unsigned CNT_LIMIT = 1 << CNT_W;
   localparam int unsigned REP_LIMIT = 1 << REP_W;

   // Per-source pattern: ON ms, OFF ms (0 = no OFF phase), repeats (0 = until stop)
   localparam int unsigned ON_MS_TAB  [N_SRC] = '{50, 100, 300, 500};
   localparam int unsigned OFF_MS_TAB [N_SRC] = '{0, 100, 200, 500};
   localparam int unsigned REPS_TAB   [N_SRC] = '{1, 2, 3, 0};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ON   = 2'd1,
      ST_OFF  = 2'd2
   } state_e;

   typedef struct packed {
      logic [CNT_W-1:0] on_ms;
      logic [CNT_W-1:0] off_ms;
      logic [REP_W-1:0] reps;
   } pattern_t;

   // Pattern lookup for a source index
   function automatic pattern_t pattern_of(input logic [SEL_W-1:0] src);
      pattern_t p;
      p.on_ms  = CNT_W'(ON_MS_TAB[src]);
      p.off_ms = CNT_W'(OFF_MS_TAB[src]);
      p.reps   = REP_W'(REPS_TAB[src]);
      return p;
   endfunction

   // Priority encoder: highest set index wins
   function automatic logic [SEL_W-1:0] highest_idx(input logic [N_SRC-1:0] v);
      logic [SEL_W-1:0] idx;
      idx = '0;
      for (int unsigned i = 0; i < N_SRC; i++) begin
         if (v[i]) idx = SEL_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/beep_scheduler_edge_strobe.sv
// Registers an external square wave and produces a one-cycle strobe on its rising edge.
module edge_strobe (
   input  logic clk_in,
   input  logic rst_n,
   input  logic sig,
   output logic rise_c
);

   logic sig_q;
   logic sig_qq;

   // Two-stage capture of the incoming square wave
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         sig_q  <= 1'b0;
         sig_qq <= 1'b0;
      end else begin
         sig_q  <= sig;
         sig_qq <= sig_q;
      end
   end

   assign rise_c = sig_q & ~sig_qq;

endmodule

// File: rtl/beep_scheduler.sv
// Arbitrates buzzer requests onto the single beeper and sequences ON/OFF/repeat patterns in ms ticks.
module beep_scheduler
   import beep_scheduler_pkg::*;
(
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic             tick_in,
   input  logic [N_SRC-1:0] req,
   input  logic             stop,
   output logic [SEL_W-1:0] snd_sel,
   output logic             beep_en,
   output logic [N_SRC-1:0] grant,
   output logic             busy,
   output logic             done
);

   state_e           state_q, state_d;
   logic [N_SRC-1:0] pending_q, pending_d;
   logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
   logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
   logic             entry_q, entry_d;
   logic [SEL_W-1:0] snd_sel_d;
   logic             beep_en_d;
   logic [N_SRC-1:0] grant_d;
   logic             busy_d;
   logic             done_d;

   logic             strobe_c;
   logic             tick_c;
   logic [CNT_W-1:0] cnt_inc_c;
   pattern_t         cur_pat_c;
   pattern_t         win_pat_c;
   logic [SEL_W-1:0] win_idx_c;
   logic [N_SRC-1:0] win_oh_c;
   logic             preempt_c;
   logic             launch_c;
   logic             phase_end_c;
   logic             last_rep_c;

   // Phase lengths must fit the tick counter, repeat counts the repeat counter
   for (genvar s = 0; s < N_SRC; s++) begin : g_len_chk
      if (ON_MS_TAB[s] >= CNT_LIMIT || OFF_MS_TAB[s] >= CNT_LIMIT || REPS_TAB[s] >= REP_LIMIT) begin : g_bad
         $error("beep_scheduler: pattern table entry out of counter range");
      end
   end

   edge_strobe u_tick (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .sig    (tick_in),
      .rise_c (strobe_c)
   );

   // Next-state, arbitration and pattern sequencing
   always_comb begin
      tick_c      = strobe_c & ~entry_q;
      cnt_inc_c   = tick_cnt_q + CNT_W'(1);
      cur_pat_c   = pattern_of(snd_sel);
      win_idx_c   = highest_idx(pending_q);
      win_pat_c   = pattern_of(win_idx_c);
      win_oh_c    = N_SRC'(1) << win_idx_c;
      last_rep_c  = (cur_pat_c.reps != '0) && (rep_cnt_q == REP_W'(1));
      preempt_c   = pending_q[ALARM_IDX] && (snd_sel != SEL_W'(ALARM_IDX));
      launch_c    = 1'b0;
      phase_end_c = 1'b0;

      state_d    = state_q;
      pending_d  = pending_q | req;
      tick_cnt_d = tick_cnt_q;
      rep_cnt_d  = rep_cnt_q;
      entry_d    = 1'b0;
      snd_sel_d  = snd_sel;
      beep_en_d  = beep_en;
      grant_d    = grant;
      busy_d     = busy;
      done_d     = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            launch_c = (pending_q != '0);
         end
         ST_ON: begin
            if (preempt_c) begin
               launch_c = 1'b1;
            end else if (tick_c) begin
               if (cnt_inc_c == cur_pat_c.on_ms) begin
                  if (cur_pat_c.off_ms != '0) begin
                     state_d    = ST_OFF;
                     beep_en_d  = 1'b0;
                     tick_cnt_d = '0;
                     entry_d    = 1'b1;
                  end else begin
                     phase_end_c = 1'b1;
                  end
               end else begin
                  tick_cnt_d = cnt_inc_c;
               end
            end
         end
         ST_OFF: begin
            if (preempt_c) begin
               launch_c = 1'b1;
            end else if (tick_c) begin
               if (cnt_inc_c == cur_pat_c.off_ms) begin
                  phase_end_c = 1'b1;
               end else begin
                  tick_cnt_d = cnt_inc_c;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // End of one ON/OFF cycle: finish or start the next repeat
      if (phase_end_c) begin
         tick_cnt_d = '0;
         if (last_rep_c) begin
            state_d   = ST_IDLE;
            done_d    = 1'b1;
            grant_d   = '0;
            busy_d    = 1'b0;
            beep_en_d = 1'b0;
            rep_cnt_d = '0;
         end else begin
            state_d   = ST_ON;
            beep_en_d = 1'b1;
            entry_d   = 1'b1;
            if (cur_pat_c.reps != '0) rep_cnt_d = rep_cnt_q - REP_W'(1);
         end
      end

      // Grant the highest pending source (new pattern or alarm preemption)
      if (launch_c) begin
         state_d    = ST_ON;
         pending_d  = (pending_q & ~win_oh_c) | req;
         grant_d    = win_oh_c;
         snd_sel_d  = win_idx_c;
         beep_en_d  = 1'b1;
         busy_d     = 1'b1;
         tick_cnt_d = '0;
         rep_cnt_d  = win_pat_c.reps;
         entry_d    = 1'b1;
      end

      // Abort overrides everything, including a coincident request
      if (stop) begin
         state_d    = ST_IDLE;
         pending_d  = '0;
         tick_cnt_d = '0;
         rep_cnt_d  = '0;
         entry_d    = 1'b0;
         beep_en_d  = 1'b0;
         grant_d    = '0;
         busy_d     = 1'b0;
         done_d     = 1'b0;
      end
   end

   // State and registered outputs
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         pending_q  <= '0;
         tick_cnt_q <= '0;
         rep_cnt_q  <= '0;
         entry_q    <= 1'b0;
         snd_sel    <= '0;
         beep_en    <= 1'b0;
         grant      <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         tick_cnt_q <= tick_cnt_d;
         rep_cnt_q  <= rep_cnt_d;
         entry_q    <= entry_d;
         snd_sel    <= snd_sel_d;
         beep_en    <= beep_en_d;
         grant      <= grant_d;
         busy       <= busy_d;
         done       <= done_d;
      end
   end

endmodule

// File: tb/tb_beep_scheduler.sv
// Scoreboard bench for beep_scheduler: pattern-level expectations checked by a free-running monitor.
module tb_beep_scheduler;
   import beep_scheduler_pkg::*;

   localparam int TICK_HALF = 1;
   localparam int TP        = 2 * TICK_HALF;
   localparam int B_ON  [4] = '{50, 100, 300, 500};
   localparam int B_OFF [4] = '{0, 100, 200, 500};
   localparam int B_REP [4] = '{1, 2, 3, 0};

   typedef struct {
      int src;
      bit completed;
      int bursts;
   } exp_t;

   logic             clk_in = 1'b0;
   logic             rst_n;
   logic             tick_in;
   logic [N_SRC-1:0] req;
   logic             stop;
   logic [SEL_W-1:0] snd_sel;
   logic             beep_en;
   logic [N_SRC-1:0] grant;
   logic             busy;
   logic             done;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];
   bit   mon_en = 1'b0;
   int   div_cnt;

   beep_scheduler dut (
      .clk_in  (clk_in),
      .rst_n   (rst_n),
      .tick_in (tick_in),
      .req     (req),
      .stop    (stop),
      .snd_sel (snd_sel),
      .beep_en (beep_en),
      .grant   (grant),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk_in = ~clk_in;

   // Scaled-down clock divider standing in for the 1 kHz tick source
   always @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= 0;
         tick_in <= 1'b0;
      end else if (div_cnt == TICK_HALF - 1) begin
         div_cnt <= 0;
         tick_in <= ~tick_in;
      end else begin
         div_cnt <= div_cnt + 1;
      end
   end

   function automatic void chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endfunction

   function automatic void chk_len(input string name, input int act, input int ms);
      checks++;
      if (act < ms * TP || act > ms * TP + TP) begin
         errors++;
         $display("FAIL %s: got %0d cycles expected %0d..%0d (t=%0t)", name, act, ms * TP, ms * TP + TP, $time);
      end
   endfunction

   // ---------------- monitor ----------------
   logic [N_SRC-1:0] prev_grant;
   bit               prev_en;
   int               seg_src, bursts, on_len, off_len;
   exp_t             seg_exp;

   function automatic void open_seg();
      int idx;
      idx = 0;
      for (int b = 0; b < N_SRC; b++) if (grant[b]) idx = b;
      chk("grant_onehot", $countones(grant), 1);
      chk("snd_sel_at_grant", int'(snd_sel), idx);
      chk("beep_on_at_grant", int'(beep_en), 1);
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_grant: got source %0d expected none (t=%0t)", idx, $time);
         seg_exp = '{src: idx, completed: 1'b0, bursts: -1};
      end else begin
         seg_exp = exp_q.pop_front();
         chk("grant_source", idx, seg_exp.src);
      end
      seg_src = idx;
      bursts  = 1;
      on_len  = 1;
      off_len = 0;
   endfunction

   function automatic void close_seg(input bit seen_done);
      chk("done_flag", int'(seen_done), int'(seg_exp.completed));
      if (seg_exp.completed && seen_done) begin
         if (prev_en) chk_len("final_on_len", on_len, B_ON[seg_src]);
         else         chk_len("final_off_len", off_len, B_OFF[seg_src]);
         if (seg_exp.bursts >= 0) chk("burst_count", bursts, seg_exp.bursts);
      end
   endfunction

   // Observes outputs mid-cycle and reconstructs patterns as segments
   always @(negedge clk_in) begin
      if (!mon_en || !rst_n) begin
         prev_grant = '0;
         prev_en    = 1'b0;
      end else begin
         chk("busy_vs_grant", int'(busy), int'(grant != '0));
         if (grant != prev_grant) begin
            if (prev_grant != '0) close_seg(done);
            else                  chk("done_at_start", int'(done), 0);
            if (grant != '0) open_seg();
         end else begin
            chk("done_without_end", int'(done), 0);
            if (grant != '0) begin
               if (beep_en) begin
                  if (!prev_en) begin
                     chk_len("off_len", off_len, B_OFF[seg_src]);
                     bursts++;
                     on_len = 0;
                  end
                  on_len++;
               end else begin
                  if (prev_en) begin
                     chk_len("on_len", on_len, B_ON[seg_src]);
                     off_len = 0;
                  end
                  off_len++;
               end
            end
         end
         prev_grant = grant;
         prev_en    = beep_en;
      end
   end

   // ---------------- stimulus ----------------
   task automatic issue(input logic [N_SRC-1:0] mask);
      @(posedge clk_in); #1;
      req = mask;
      @(posedge clk_in); #1;
      req = '0;
   endtask

   task automatic push_mask(input logic [N_SRC-1:0] mask);
      for (int b = N_SRC - 1; b >= 0; b--) begin
         if (mask[b]) exp_q.push_back('{src: b, completed: 1'b1, bursts: B_REP[b]});
      end
   endtask

   task automatic wait_idle();
      int quiet = 0;
      int n     = 0;
      while (quiet < 4 && n < 20000) begin
         @(posedge clk_in); #1;
         n++;
         if (busy) quiet = 0;
         else      quiet++;
      end
      checks++;
      if (quiet < 4) begin
         errors++;
         $display("FAIL wait_idle: still busy after %0d cycles expected idle", n);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   task automatic alarm_req();
      @(posedge clk_in); #1;
      req = 4'b1000;
      @(posedge clk_in); #1;
      req = '0;
      @(posedge clk_in); #1;
      chk("preempt_grant", int'(grant), 8);
      chk("preempt_snd_sel", int'(snd_sel), 3);
   endtask

   task automatic stop_req(input logic [N_SRC-1:0] also_req);
      @(posedge clk_in); #1;
      stop = 1'b1;
      req  = also_req;
      @(posedge clk_in); #1;
      stop = 1'b0;
      req  = '0;
      chk("stop_grant", int'(grant), 0);
      chk("stop_beep_en", int'(beep_en), 0);
      chk("stop_busy", int'(busy), 0);
      chk("stop_done", int'(done), 0);
      wait_cycles(6);
      chk("stop_pending_cleared", int'(busy), 0);
   endtask

   function automatic int top_bit(input logic [N_SRC-1:0] mask);
      int hi = 0;
      for (int b = 0; b < N_SRC; b++) if (mask[b]) hi = b;
      return hi;
   endfunction

   initial begin
      rst_n = 1'b0;
      req   = '0;
      stop  = 1'b0;
      #23;
      chk("reset_snd_sel", int'(snd_sel), 0);
      chk("reset_beep_en", int'(beep_en), 0);
      chk("reset_grant", int'(grant), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      rst_n = 1'b1;
      @(posedge clk_in); #1;
      mon_en = 1'b1;

      // Single short beep
      push_mask(4'b0001);
      issue(4'b0001);
      wait_idle();

      // Three-burst pattern
      push_mask(4'b0100);
      issue(4'b0100);
      wait_idle();

      // Simultaneous requests: higher index first
      push_mask(4'b0011);
      issue(4'b0011);
      wait_idle();

      // Alarm preempts source 2, then abort
      exp_q.push_back('{src: 2, completed: 1'b0, bursts: -1});
      exp_q.push_back('{src: 3, completed: 1'b0, bursts: -1});
      issue(4'b0100);
      wait_cycles(40);
      alarm_req();
      wait_cycles(2500);
      stop_req(4'b0000);

      // Re-request while own pattern plays -> replay
      push_mask(4'b0001);
      push_mask(4'b0001);
      issue(4'b0001);
      wait_cycles(20);
      issue(4'b0001);
      wait_idle();

      // Randomised mix of plain, preempted and aborted transactions
      for (int it = 0; it < 10; it++) begin
         int               kind;
         int               hi;
         logic [N_SRC-1:0] mask;
         kind = int'($urandom_range(0, 3));
         mask = N_SRC'($urandom_range(1, 7));
         hi   = top_bit(mask);
         if (kind <= 1) begin
            push_mask(mask);
            issue(mask);
            wait_idle();
         end else if (kind == 2) begin
            exp_q.push_back('{src: hi, completed: 1'b0, bursts: -1});
            exp_q.push_back('{src: 3, completed: 1'b0, bursts: -1});
            issue(mask);
            wait_cycles(int'($urandom_range(4, 90)));
            alarm_req();
            wait_cycles(int'($urandom_range(10, 2500)));
            stop_req(4'b0000);
         end else begin
            exp_q.push_back('{src: hi, completed: 1'b0, bursts: -1});
            issue(mask);
            wait_cycles(int'($urandom_range(4, 90)));
            stop_req(N_SRC'($urandom_range(0, 7)));
         end
      end

      // Asynchronous reset in the middle of an ON phase
      exp_q.push_back('{src: 2, completed: 1'b0, bursts: -1});
      issue(4'b0110);
      wait_cycles(50);
      mon_en = 1'b0;
      @(posedge clk_in); #3;
      rst_n = 1'b0;
      #1;
      chk("async_rst_grant", int'(grant), 0);
      chk("async_rst_beep_en", int'(beep_en), 0);
      chk("async_rst_busy", int'(busy), 0);
      chk("async_rst_snd_sel", int'(snd_sel), 0);
      #8;
      rst_n = 1'b1;
      wait_cycles(8);
      chk("post_rst_idle_grant", int'(grant), 0);
      chk("post_rst_idle_busy", int'(busy), 0);

      chk("scoreboard_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
